// File: rtl/softmax_pkg.sv
// softmax_pkg: shared FP32 field widths, special encodings and accumulator FSM states
package softmax_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_MAX     = 32'h7F7FFFFF;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
endpackage

// File: rtl/softmax_accumulator_fp32_addsub.sv
// fp32_addsub: combinational FP32 a +/- b, round-to-nearest-even, denormals flushed to signed zero
// Ports: a_i, b_i operands; sub_i flips b's sign; y_o result; ovf_o finite+finite sum overflowed.
// SOFTMAX_ACC_SAT_EN: overflow saturates to +/-FP32_MAX instead of +/-Inf.
module fp32_addsub
  import softmax_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] y_o,
  output logic        ovf_o
);
  localparam logic signed [9:0] EMAX = 10'(2 * BIAS);
  logic [31:0] bb, big, sml;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, carry;
  logic [EXP_W-1:0] d;
  logic [4:0] sh, lz;
  logic [50:0] x;
  logic [26:0] al, n;
  logic [27:0] sum;
  logic [24:0] rnd;
  logic signed [9:0] e_n, e_r;
  always_comb begin
    bb     = {b_i[31] ^ sub_i, b_i[30:0]};
    a_nan  = (&a_i[30:23]) & (|a_i[MAN_W-1:0]);
    b_nan  = (&bb[30:23]) & (|bb[MAN_W-1:0]);
    a_inf  = (&a_i[30:23]) & ~(|a_i[MAN_W-1:0]);
    b_inf  = (&bb[30:23]) & ~(|bb[MAN_W-1:0]);
    a_zero = ~(|a_i[30:23]);
    b_zero = ~(|bb[30:23]);
    swap   = bb[30:0] > a_i[30:0];
    big    = swap ? bb : a_i;
    sml    = swap ? a_i : bb;
    d      = big[30:23] - sml[30:23];
    sh     = (d > 8'd31) ? 5'd31 : d[4:0];
    // align the smaller mantissa; everything below the round bit collapses into sticky
    x      = {1'b1, sml[22:0], 27'b0} >> sh;
    al     = {x[50:25], x[24] | (|x[23:0])};
    sum    = (big[31] == sml[31]) ? {2'b01, big[22:0], 3'b0} + {1'b0, al}
                                  : {2'b01, big[22:0], 3'b0} - {1'b0, al};
    carry  = sum[27];
    lz     = '0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    n      = carry ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << lz;
    rnd    = {1'b0, n[26:3]} + 25'(n[2] & (n[1] | n[0] | n[3]));
    e_n    = carry ? $signed({2'b0, big[30:23]}) + 10'sd1
                   : $signed({2'b0, big[30:23]}) - $signed({5'b0, lz});
    e_r    = e_n + $signed({9'b0, rnd[24]});
    ovf_o  = 1'b0;
    y_o    = {big[31], e_r[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != bb[31]))) y_o = FP32_QNAN;
    else if (a_inf) y_o = a_i;
    else if (b_inf) y_o = bb;
    else if (a_zero && b_zero) y_o = {a_i[31] & bb[31], 31'b0};
    else if (a_zero) y_o = bb;
    else if (b_zero) y_o = a_i;
    else if (sum == '0) y_o = '0;
    else if (e_r < 10'sd1) y_o = {big[31], 31'b0};
    else if (e_r > EMAX) begin
      ovf_o = 1'b1;
`ifdef SOFTMAX_ACC_SAT_EN
      y_o = {big[31], FP32_MAX[30:0]};
`else
      y_o = big[31] ? FP32_NEG_INF : FP32_POS_INF;
`endif
    end
  end
endmodule

// File: rtl/softmax_accumulator.sv
// softmax_accumulator: folds LEN streamed FP32 operands into an initial value, one result per vector
// Ports: clk_i, rst_ni (async active-low); start_i/init_val_i/sub_i begin a vector in IDLE;
// in_valid_i/in_data_i/in_ready_o operand stream; out_valid_o/out_data_o/out_ready_i result;
// busy_o in ACCUM/DONE; overflow_o sticky per vector.
// SOFTMAX_ACC_SAT_EN: overflowing sums saturate to +/-FP32_MAX (see fp32_addsub).
module softmax_accumulator
  import softmax_pkg::*;
#(
  parameter int unsigned LEN = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] init_val_i,
  input  logic        sub_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        overflow_o
);
  localparam int CNT_W = $clog2(LEN + 1);
  acc_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d, sum;
  logic mode_q, mode_d, ovf_q, ovf_d, ovf;
  fp32_addsub u_add (
    .a_i  (acc_q),
    .b_i  (in_data_i),
    .sub_i(mode_q),
    .y_o  (sum),
    .ovf_o(ovf)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = ACCUM;
        acc_d   = init_val_i;
        mode_d  = sub_i;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      ACCUM: if (in_valid_i) begin
        acc_d   = sum;
        cnt_d   = cnt_q + CNT_W'(1);
        ovf_d   = ovf_q | ovf;
        state_d = (cnt_q == CNT_W'(LEN - 1)) ? DONE : ACCUM;
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready_o  = state_q == ACCUM;
    out_valid_o = state_q == DONE;
    out_data_o  = out_valid_o ? acc_q : '0;
    busy_o      = state_q != IDLE;
    overflow_o  = ovf_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_softmax_accumulator.sv
// tb_softmax_accumulator: directed and random vectors against a real-arithmetic FP32 reference
module tb_softmax_accumulator;
  localparam int LEN = 4;
  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, sub_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] init_val_i = '0, in_data_i = '0, out_data_o;
  logic in_ready_o, out_valid_o, busy_o, overflow_o;
  logic [31:0] ops [4];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  softmax_accumulator #(.LEN(LEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .init_val_i(init_val_i), .sub_i(sub_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    if (f[30:23] == 8'd0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
  endfunction

  // reference: exact sum in double precision, then one RNE rounding to FP32
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, output bit ov);
    bit an, bn, ai, bi, s;
    real r;
    logic [63:0] bits;
    int e;
    int unsigned keep, rem;
    ov = 1'b0;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;
    bi = b[30:23] == 8'hFF && b[22:0] == 0;
    if (an || bn || (ai && bi && a[31] != b[31])) return 32'h7FC00000;
    if (ai) return a;
    if (bi) return b;
    if (a[30:23] == 0 && b[30:23] == 0) return {a[31] & b[31], 31'b0};
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 32'h0;
    bits = $realtobits(r);
    s = bits[63];
    e = int'(bits[62:52]) - 896;
    keep = {8'b0, 1'b1, bits[51:29]};
    rem = {3'b0, bits[28:0]};
    if (rem > 32'h10000000 || (rem == 32'h10000000 && keep[0])) keep++;
    if (keep == 32'h01000000) begin keep = keep >> 1; e++; end
    if (e >= 255) begin
      ov = 1'b1;
`ifdef SOFTMAX_ACC_SAT_EN
      return {s, 31'h7F7FFFFF};
`else
      return {s, 31'h7F800000};
`endif
    end
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] init, input logic sub,
                         input int gap, input int hold, input logic [31:0] exp_y, input logic exp_ov);
    @(posedge clk); #1;
    start_i = 1'b1; init_val_i = init; sub_i = sub;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk($sformatf("%s.ready", tag), {31'b0, in_ready_o}, 32'd1);
    for (int k = 0; k < LEN; k++) begin
      in_valid_i = 1'b1; in_data_i = ops[k];
      @(posedge clk); #1;
      in_valid_i = 1'b0; in_data_i = 32'hFFFFFFFF;
      if (k == LEN - 2) chk($sformatf("%s.early_valid", tag), {31'b0, out_valid_o}, 32'd0);
      if (k < LEN - 1)
        repeat (gap) begin
          start_i = 1'b1; init_val_i = 32'hDEADBEEF;
          @(posedge clk); #1;
          start_i = 1'b0;
        end
    end
    chk($sformatf("%s.valid", tag), {31'b0, out_valid_o}, 32'd1);
    chk($sformatf("%s.data", tag), out_data_o, exp_y);
    chk($sformatf("%s.ovf", tag), {31'b0, overflow_o}, {31'b0, exp_ov});
    repeat (hold) begin
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk($sformatf("%s.hold", tag), {out_valid_o, out_data_o[30:0]}, {1'b1, exp_y[30:0]});
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk($sformatf("%s.idle", tag), {30'b0, busy_o, out_valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] acc;
    logic sub;
    bit ov, o;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {out_data_o[30:0], in_ready_o}, 32'd0);
    chk("reset.flags", {29'b0, out_valid_o, busy_o, overflow_o}, 32'd0);
    rst_ni = 1'b1;

    ops = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_vec("sum4", 32'h0, 1'b0, 0, 0, 32'h40800000, 1'b0);
    ops = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    run_vec("sub", 32'h3F800000, 1'b1, 0, 0, 32'hBF800000, 1'b0);
    ops = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_vec("stall", 32'h0, 1'b0, 2, 5, 32'h40800000, 1'b0);
    ops = '{32'h7F7FFFFF, 32'h0, 32'h0, 32'h0};
`ifdef SOFTMAX_ACC_SAT_EN
    run_vec("ovf", 32'h7F7FFFFF, 1'b0, 0, 1, 32'h7F7FFFFF, 1'b1);
`else
    run_vec("ovf", 32'h7F7FFFFF, 1'b0, 0, 1, 32'h7F800000, 1'b1);
`endif
    ops = '{32'h3F800000, 32'h7FC00123, 32'h3F800000, 32'h3F800000};
    run_vec("nan", 32'h0, 1'b0, 0, 0, 32'h7FC00000, 1'b0);
    ops = '{32'h7F800000, 32'hFF800000, 32'h0, 32'h0};
    run_vec("inf", 32'h0, 1'b0, 0, 0, 32'h7FC00000, 1'b0);
    ops = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    run_vec("denorm", 32'h0, 1'b0, 0, 0, 32'h00000000, 1'b0);
    ops = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    run_vec("negzero", 32'h80000000, 1'b0, 0, 0, 32'h80000000, 1'b0);

    @(posedge clk); #1;
    start_i = 1'b1; init_val_i = 32'h0; sub_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h40000000;
    repeat (2) @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("abort", {out_data_o[30:0], in_ready_o}, 32'd0);
    chk("abort.flags", {29'b0, out_valid_o, busy_o, overflow_o}, 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    ops = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_vec("fresh", 32'h0, 1'b0, 0, 0, 32'h40800000, 1'b0);

    for (int v = 0; v < 16; v++) begin
      acc = rnd_f();
      sub = 1'($urandom);
      init_val_i = acc;
      ov = 1'b0;
      for (int k = 0; k < LEN; k++) begin
        ops[k] = rnd_f();
        acc = fadd(acc, {ops[k][31] ^ sub, ops[k][30:0]}, o);
        ov |= o;
      end
      run_vec($sformatf("rand%0d", v), init_val_i, sub, $urandom_range(0, 2), $urandom_range(0, 3), acc, ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
